os_psum_drain: RTL and testbench
================================

Name: os_psum_drain

Overview:
- Sits directly downstream of one row of output-stationary mac tiles (mode = 1).
- Captures each tile's accumulated psum when that tile raises its per-tile ready pulse, and assembles a full row vector.
- Double-buffers the vector so capture of the next accumulation window overlaps draining of the previous one.
- Streams the vector one psum per beat, with optional ReLU, to the output SRAM writer over a valid/ready handshake.

Parameters:
- col, 8, number of tiles in the row (capture slots).
- psum_bw, 16, psum width per tile (two's complement).
- addr_bw, 6, output row-address width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- os_ready  input  col  per-tile capture pulse; bit i corresponds to tile i.
- os_output  input  col*psum_bw  per-tile psum; tile i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].
- relu_en  input  1  apply ReLU to the vector; sampled at bank swap.
- clr_err  input  1  clears the sticky overflow flag.
- out_valid  output  1  out_data, out_col and out_addr are valid.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  psum_bw  drained psum.
- out_col  output  log2(col) (min 1)  slot index of out_data.
- out_addr  output  addr_bw  row address of the current vector.
- busy  output  1  high while draining or while any capture slot is valid.
- overflow  output  1  sticky error flag.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_col=0, out_addr=0, busy=0, overflow=0; all capture/drain valids=0; FSM in IDLE.
- Capture bank: col registers cap_d[i] plus valid bits cap_v[i].
  - os_ready[i]=1 and cap_v[i]=0: cap_d[i] <= os_output slice i; cap_v[i] <= 1. Any subset of bits may pulse in the same cycle.
  - os_ready[i]=1 and cap_v[i]=1: data is kept (old value wins), overflow <= 1.
- Drain bank: col registers drn_d[i], drn_relu flag, FSM with states IDLE and DRAIN.
- IDLE -> DRAIN when all cap_v are 1. In that cycle:
  - drn_d <= cap_d, with ReLU applied at copy time if relu_en=1 (negative values become 0, non-negative pass through).
  - all cap_v <= 0, except a slot whose os_ready bit is also high in that cycle. That slot captures new data and its valid stays 1 (set wins over clear), with no overflow.
  - out_col <= 0; out_valid <= 1 on the next cycle. The swap costs one cycle: a full bank first appears on out_valid one cycle after the last capture.
- DRAIN:
  - out_data = drn_d[out_col]; out_valid=1.
  - Beat fires when out_valid and out_ready are both 1.
  - On a fire with out_col < col-1: out_col increments.
  - On a fire with out_col = col-1: out_valid <= 0, out_addr <= out_addr+1 (wraps from 2^addr_bw-1 to 0), go to IDLE.
  - out_data, out_col and out_addr hold stable while out_valid=1 and out_ready=0.
- A capture bank that fills while in DRAIN waits. It swaps in the cycle after the last beat fires (IDLE with all cap_v set), so back-to-back vectors have one idle bubble.
- Capture continues in all states. Overflow only occurs if a tile pulses again before its slot is swapped out.
- overflow: sticky once set. clr_err=1 clears it, except in a cycle where a new overflow occurs (set wins).
- busy = (state==DRAIN) OR (any cap_v).
- Reset mid-drain: the in-flight vector and partial captures are discarded, out_addr returns to 0, out_valid drops asynchronously.

Test Plan:
- col=8: pulse all os_ready bits in one cycle with psums 1..8, out_ready=1 -> out_valid rises 2 cycles after the pulse; beats out_col 0..7 carry 1..8 on consecutive cycles; out_addr=0 during the vector, then 1; busy falls after the last beat.
- Stagger captures, one bit per cycle (bit i at cycle i, value -3+i), relu_en=1 -> drained values are 0,0,0,0,1,2,3,4; no swap before bit 7 arrives.
- out_ready toggles 1,0,0,1,... during a drain -> out_data/out_col hold during stalls; exactly 8 beats; no duplicate or skipped column.
- During a drain, capture a second full vector (values 100..107), then pulse os_ready[3] again -> overflow=1, slot 3 keeps 103; second vector drains at out_addr=1 after a one-cycle bubble; clr_err clears overflow.
- os_ready[0] (value 55) coincides with the swap cycle -> slot 0 of the new capture bank holds 55 with valid set; no overflow.
- Assert reset mid-drain at out_col=4 with out_addr=5 -> out_valid, out_addr, busy and overflow are 0 immediately; the next full vector drains from out_col 0 at out_addr 0.

Source files
------------

// File: rtl/os_psum_drain_if.sv
// os_psum_drain output stream bundle.
// Drain side is master, SRAM writer side is slave.
interface os_psum_drain_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 6
);
  localparam int cw = (col > 1) ? $clog2(col) : 1;

  logic               out_valid;
  logic               out_ready;
  logic [psum_bw-1:0] out_data;
  logic [cw-1:0]      out_col;
  logic [addr_bw-1:0] out_addr;

  modport master (
    output out_valid,
    output out_data,
    output out_col,
    output out_addr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_col,
    input  out_addr,
    output out_ready
  );
endinterface

// File: rtl/os_psum_drain.sv
// Output-stationary psum row drain.
// Double-buffered capture/drain banks with optional ReLU.
module os_psum_drain #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         os_ready,
  input  logic [col*psum_bw-1:0] os_output,
  input  logic                   relu_en,
  input  logic                   clr_err,
  os_psum_drain_if.master        out_if,
  output logic                   busy,
  output logic                   overflow
);
  localparam int cw = (col > 1) ? $clog2(col) : 1;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [psum_bw-1:0] cap_d [col];
  logic [col-1:0]     cap_v;
  logic [psum_bw-1:0] drn_d [col];
  logic [cw-1:0]      col_q;
  logic [addr_bw-1:0] addr_q;
  logic               all_v;
  logic               swap;
  logic               fire;
  logic               last;
  logic               ov_hit;

  assign all_v  = &cap_v;
  assign swap   = (state_q == IDLE) && all_v;
  assign fire   = (state_q == DRAIN) && out_if.out_ready;
  assign last   = (col_q == cw'(col - 1));
  // A pulse into the swapping slot refills it, so it is not an overflow.
  assign ov_hit = (|(os_ready & cap_v)) && !swap;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: swap when the capture bank is full, return after last beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (all_v) state_d = DRAIN;
      DRAIN: if (fire && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture bank: first pulse per window wins; swap clears unless refilled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_v <= '0;
      for (int i = 0; i < col; i++) cap_d[i] <= '0;
    end else begin
      for (int i = 0; i < col; i++) begin
        if (os_ready[i] && (swap || !cap_v[i]))
          cap_d[i] <= os_output[psum_bw*i +: psum_bw];
        cap_v[i] <= swap ? os_ready[i] : (cap_v[i] | os_ready[i]);
      end
    end
  end

  // Drain bank: copy on swap, ReLU applied at copy time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < col; i++) drn_d[i] <= '0;
    end else if (swap) begin
      for (int i = 0; i < col; i++)
        drn_d[i] <= (relu_en && cap_d[i][psum_bw-1]) ? '0 : cap_d[i];
    end
  end

  // Column walk and row address advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      addr_q <= '0;
    end else if (swap) begin
      col_q <= '0;
    end else if (fire) begin
      if (last) addr_q <= addr_q + addr_bw'(1);
      else      col_q  <= col_q + cw'(1);
    end
  end

  // Sticky overflow; a new hit beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overflow <= 1'b0;
    else if (ov_hit)  overflow <= 1'b1;
    else if (clr_err) overflow <= 1'b0;
  end

  assign out_if.out_valid = (state_q == DRAIN);
  assign out_if.out_data  = out_if.out_valid ? drn_d[col_q] : '0;
  assign out_if.out_col   = col_q;
  assign out_if.out_addr  = addr_q;
  assign busy             = (state_q == DRAIN) || (|cap_v);
endmodule

// File: tb/tb_os_psum_drain.sv
// Directed bench for os_psum_drain.
// Scoreboard queue checked on each fired beat.
module tb_os_psum_drain;
  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   os_ready;
  logic [127:0] os_output;
  logic         relu_en;
  logic         clr_err;
  logic         busy;
  logic         overflow;

  os_psum_drain_if #(.col(8), .psum_bw(16), .addr_bw(6)) oif ();

  os_psum_drain #(.col(8), .psum_bw(16), .addr_bw(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .os_ready (os_ready),
    .os_output(os_output),
    .relu_en  (relu_en),
    .clr_err  (clr_err),
    .out_if   (oif),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  c;
    logic [5:0]  a;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [7:0] rdy, input int base);
    os_ready = rdy;
    for (int i = 0; i < 8; i++)
      os_output[16*i +: 16] = 16'(base + i);
    tick();
    os_ready = '0;
  endtask

  task automatic push_vec(input int base, input bit relu, input int addr,
                          input bit s0, input int v0);
    exp_t e;
    int v;
    for (int i = 0; i < 8; i++) begin
      v = (s0 && i == 0) ? v0 : base + i;
      if (relu && v < 0) v = 0;
      e.d = 16'(v);
      e.c = 3'(i);
      e.a = 6'(addr);
      q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int left, input bit toggle);
    int n = 0;
    while (q.size() > left && n < 300) begin
      oif.out_ready = toggle ? (n % 3 == 0) : 1'b1;
      tick();
      n++;
    end
    oif.out_ready = 1'b1;
    chk("drain_timeout", q.size(), left);
  endtask

  // Monitor: hold stability on stalls, scoreboard compare on fires.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_d;
  logic [2:0]  prev_c;
  logic [5:0]  prev_a;
  always @(negedge clk) begin
    exp_t e;
    if (reset || !oif.out_valid) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_data", oif.out_data, prev_d);
        chk("hold_col", oif.out_col, prev_c);
        chk("hold_addr", oif.out_addr, prev_a);
      end
      prev_stall = !oif.out_ready;
      prev_d = oif.out_data;
      prev_c = oif.out_col;
      prev_a = oif.out_addr;
      if (oif.out_ready) begin
        chk("beat_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("beat_data", oif.out_data, e.d);
          chk("beat_col", oif.out_col, e.c);
          chk("beat_addr", oif.out_addr, e.a);
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    os_ready = '0;
    os_output = '0;
    relu_en = 1'b0;
    clr_err = 1'b0;
    oif.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", oif.out_valid, 0);
    chk("rst_data", oif.out_data, 0);
    chk("rst_col", oif.out_col, 0);
    chk("rst_addr", oif.out_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    tick();

    // Full vector in one cycle.
    push_vec(1, 0, 0, 0, 0);
    cap(8'hFF, 1);
    chk("t1_valid_lat1", oif.out_valid, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_valid_lat2", oif.out_valid, 1);
    chk("t1_col0", oif.out_col, 0);
    chk("t1_addr0", oif.out_addr, 0);
    wait_drain(0, 0);
    chk("t1_valid_end", oif.out_valid, 0);
    chk("t1_addr1", oif.out_addr, 1);
    chk("t1_busy_end", busy, 0);

    // Staggered capture with ReLU.
    relu_en = 1'b1;
    push_vec(-3, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cap(8'(1 << i), -3);
      chk("t2_no_swap", oif.out_valid, 0);
    end
    tick();
    chk("t2_swap", oif.out_valid, 1);
    relu_en = 1'b0;
    wait_drain(0, 0);

    // Backpressure.
    push_vec(10, 0, 2, 0, 0);
    cap(8'hFF, 10);
    wait_drain(0, 1);
    chk("t3_addr", oif.out_addr, 3);

    // Second vector during drain, plus overflow on slot 3.
    push_vec(20, 0, 3, 0, 0);
    cap(8'hFF, 20);
    tick();
    push_vec(100, 0, 4, 0, 0);
    cap(8'hFF, 100);
    cap(8'h08, 996);
    chk("t4_ovf", overflow, 1);
    wait_drain(8, 0);
    chk("t4_bubble", oif.out_valid, 0);
    tick();
    chk("t4_second", oif.out_valid, 1);
    chk("t4_addr", oif.out_addr, 4);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_clr", overflow, 0);
    wait_drain(0, 0);

    // Reset mid-drain at out_col=4, out_addr=5.
    push_vec(40, 0, 5, 0, 0);
    cap(8'hFF, 40);
    tick();
    cap(8'h01, 70);
    cap(8'h01, 71);
    chk("t6_ovf_pre", overflow, 1);
    n = 0;
    while (!(oif.out_valid && oif.out_col == 3'd4) && n < 50) begin
      tick();
      n++;
    end
    chk("t6_reach_col4", oif.out_col, 4);
    chk("t6_addr5", oif.out_addr, 5);
    reset = 1'b1;
    #1;
    chk("t6_valid", oif.out_valid, 0);
    chk("t6_addr", oif.out_addr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ovf", overflow, 0);
    q.delete();
    tick();
    reset = 1'b0;
    tick();

    // Capture coinciding with swap.
    push_vec(30, 0, 0, 0, 0);
    cap(8'hFF, 30);
    cap(8'h01, 55);
    chk("t5_ovf", overflow, 0);
    chk("t5_busy", busy, 1);
    chk("t5_col0", oif.out_col, 0);
    push_vec(60, 0, 1, 1, 55);
    cap(8'hFE, 60);
    wait_drain(0, 0);
    chk("t5_ovf_end", overflow, 0);
    chk("t5_busy_end", busy, 0);
    chk("t5_addr_end", oif.out_addr, 2);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
